sad_accum_select: RTL and testbench

// Sits directly downstream of the per-line fractional-pel abs-diff stage.
// - Consumes its 25 per-line difference vectors, 6 absolute differences each.
// - Accumulates them over the 6 lines of the inner 6x6 block, producing 25 SADs.
// - Scans those SADs sequentially and reports the minimum and its quarter-pel offset.
// - Provides valid/ready handshakes on both sides.

---
 rtl/sad_accum_select.sv | 145 ++++++++++++++
 tb/tb_sad_accum_select.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum_select.sv
// Accumulates 25 candidate line SADs over an inner block, then scans them sequentially
// for the minimum. Reports the minimum's index and its signed quarter-pel offset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCUM  | accepting lines, acc[] built up over LINES transfers
// ST_SEARCH | 25-cycle scan of acc[] for the minimum, one entry per cycle
// ST_DONE   | result presented, waiting for out_ready
module sad_accum_select #(
    parameter int LINES  = 6,
    parameter int PIX    = 6,
    parameter int DATA_W = 8,
    parameter int SAD_W  = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [25*PIX*DATA_W-1:0] diff_all,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SAD_W-1:0]         best_sad,
    output logic [4:0]               best_idx,
    output logic [2:0]               best_dy,
    output logic [2:0]               best_dx
);

    localparam int         NCAND    = 25;
    localparam int         LC_W     = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [4:0] CENTRE   = 5'd12;
    localparam logic [4:0] LAST_PTR = 5'd24;

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state;
    logic [LC_W-1:0]  line_cnt;
    logic [4:0]       ptr;
    logic [SAD_W-1:0] acc      [NCAND];
    logic [SAD_W-1:0] line_sum [NCAND];
    logic [SAD_W-1:0] run_best;
    logic [4:0]       run_idx;
    logic [SAD_W-1:0] cmp_base;
    logic [4:0]       base_idx;
    logic [SAD_W-1:0] cmp_val;
    logic [SAD_W-1:0] next_best;
    logic [4:0]       next_idx;
    logic             take_line;
    logic             line_first;
    logic             line_last;
    logic [2:0]       best_row;
    logic [2:0]       best_col;

    assign in_ready   = (state == ST_ACCUM);
    assign out_valid  = (state == ST_DONE);
    assign take_line  = in_valid & in_ready;
    assign line_first = (line_cnt == '0);
    assign line_last  = (line_cnt == LC_W'(LINES - 1));

    // Summing directly at SAD_W keeps the wrap behaviour identical to a wide sum truncated later.
    always_comb begin
        for (int k = 0; k < NCAND; k++) begin
            line_sum[k] = '0;
            for (int p = 0; p < PIX; p++) begin
                line_sum[k] = line_sum[k] + SAD_W'(diff_all[(k*PIX + p)*DATA_W +: DATA_W]);
            end
        end
    end

    // First line of a block overwrites, so no separate clear cycle is needed.
    always_ff @(posedge clk) begin
        if (take_line) begin
            for (int k = 0; k < NCAND; k++) begin
                acc[k] <= line_first ? line_sum[k] : acc[k] + line_sum[k];
            end
        end
    end

    // Seeding with the centre plus a strict compare gives the centre-first, then lowest-index tie rule.
    always_comb begin
        cmp_base  = (ptr == '0) ? acc[CENTRE] : run_best;
        base_idx  = (ptr == '0) ? CENTRE : run_idx;
        cmp_val   = acc[ptr];
        next_best = cmp_base;
        next_idx  = base_idx;
        if (cmp_val < cmp_base) begin
            next_best = cmp_val;
            next_idx  = ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ACCUM;
            line_cnt <= '0;
            ptr      <= '0;
            run_best <= '0;
            run_idx  <= CENTRE;
            best_sad <= '0;
            best_idx <= CENTRE;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (take_line) begin
                        if (line_last) begin
                            line_cnt <= '0;
                            ptr      <= '0;
                            state    <= ST_SEARCH;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    run_best <= next_best;
                    run_idx  <= next_idx;
                    if (ptr == LAST_PTR) begin
                        ptr      <= '0;
                        best_sad <= next_best;
                        best_idx <= next_idx;
                        state    <= ST_DONE;
                    end else begin
                        ptr <= ptr + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

    // Offsets follow the registered index, so they inherit its stability and reset value (12 -> 0,0).
    assign best_row = 3'(best_idx / 5'd5);
    assign best_col = 3'(best_idx % 5'd5);
    assign best_dy  = best_row - 3'd2;
    assign best_dx  = best_col - 3'd2;

endmodule

// File: tb/tb_sad_accum_select.sv
// Bench for sad_accum_select: directed table, hand-written stall/reset sequences,
// and random blocks checked against a plain-arithmetic reference model.
module tb_sad_accum_select;

    localparam int PIX    = 6;
    localparam int DATA_W = 8;
    localparam int SAD_W  = 14;
    localparam int NC     = 25;
    localparam int DW     = NC*PIX*DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     diff_all;
    logic              out_valid;
    logic              out_ready;
    logic [SAD_W-1:0]  best_sad;
    logic [4:0]        best_idx;
    logic [2:0]        best_dy;
    logic [2:0]        best_dx;

    int total = 0;
    int bad   = 0;
    int msad [NC];

    typedef struct {
        logic [24:0][7:0] p0;
        logic [24:0][7:0] rest;
        int               sad;
        int               idx;
        int               dy;
        int               dx;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    sad_accum_select #(
        .LINES  (6),
        .PIX    (PIX),
        .DATA_W (DATA_W),
        .SAD_W  (SAD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff_all  (diff_all),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .best_sad  (best_sad),
        .best_idx  (best_idx),
        .best_dy   (best_dy),
        .best_dx   (best_dx)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] make_line(input logic [24:0][7:0] p0, input logic [24:0][7:0] rest);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < PIX; p++)
                d[(k*PIX + p)*DATA_W +: DATA_W] = (p == 0) ? p0[k] : rest[k];
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_line(input int maxv);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < NC*PIX; i++)
            d[i*DATA_W +: DATA_W] = 8'($urandom_range(0, maxv));
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) msad[k] = 0;
    endtask

    task automatic model_add(input logic [DW-1:0] d);
        for (int k = 0; k < NC; k++)
            for (int p = 0; p < PIX; p++)
                msad[k] = (msad[k] + int'(d[(k*PIX + p)*DATA_W +: DATA_W])) % (1 << SAD_W);
    endtask

    // Minimum value; centre wins a tie, otherwise the first candidate holding it.
    task automatic model_best(output int s, output int idx);
        int mn;
        mn = msad[0];
        for (int k = 1; k < NC; k++) if (msad[k] < mn) mn = msad[k];
        s = mn;
        idx = -1;
        if (msad[12] == mn) idx = 12;
        else for (int k = NC-1; k >= 0; k--) if (msad[k] == mn) idx = k;
    endtask

    task automatic push_line(input logic [DW-1:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        diff_all = d;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("push timeout", 0, 1);
        else tick();
        in_valid = 1'b0;
        model_add(d);
    endtask

    task automatic collect(input string tag, input int es, input int ei, input int edy, input int edx, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            check({tag, " timeout"}, 0, 1);
            return;
        end
        if (exp_lat >= 0) check({tag, " latency"}, n, exp_lat);
        check({tag, " sad"}, int'(best_sad), es);
        check({tag, " idx"}, int'(best_idx), ei);
        check({tag, " dy"}, int'($signed(best_dy)), edy);
        check({tag, " dx"}, int'($signed(best_dx)), edx);
        tick();
        check({tag, " handoff"}, int'(out_valid), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " in_ready"}, int'(in_ready), 1);
        check({tag, " best_sad"}, int'(best_sad), 0);
        check({tag, " best_idx"}, int'(best_idx), 12);
        check({tag, " best_dy"}, int'($signed(best_dy)), 0);
        check({tag, " best_dx"}, int'($signed(best_dx)), 0);
    endtask

    initial begin
        int s, i, n, cnt, maxv;
        logic [DW-1:0] x;
        logic [SAD_W-1:0] hold_sad;
        logic [4:0] hold_idx;
        logic [2:0] hold_dy, hold_dx;

        for (int k = 0; k < NC; k++) begin
            vecs[0].p0[k] = 8'd2;   vecs[0].rest[k] = 8'd2;
            vecs[1].p0[k] = 8'd5;   vecs[1].rest[k] = 8'd5;
            vecs[2].p0[k] = 8'd2;   vecs[2].rest[k] = 8'd0;
            vecs[3].p0[k] = 8'd255; vecs[3].rest[k] = 8'd255;
        end
        vecs[0].p0[7] = 8'd1;    vecs[0].rest[7] = 8'd1;
        vecs[2].p0[3] = 8'd1;    vecs[2].p0[20] = 8'd1;
        vecs[3].p0[24] = 8'd254; vecs[3].rest[24] = 8'd254;
        vecs[0].sad = 36;   vecs[0].idx = 7;  vecs[0].dy = -1; vecs[0].dx = 0;
        vecs[1].sad = 180;  vecs[1].idx = 12; vecs[1].dy = 0;  vecs[1].dx = 0;
        vecs[2].sad = 6;    vecs[2].idx = 3;  vecs[2].dy = -2; vecs[2].dx = 1;
        vecs[3].sad = 9144; vecs[3].idx = 24; vecs[3].dy = 2;  vecs[3].dx = 2;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        diff_all = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("init");

        for (int v = 0; v < 4; v++) begin
            x = make_line(vecs[v].p0, vecs[v].rest);
            model_reset();
            for (int l = 0; l < 6; l++) push_line(x, 0);
            collect($sformatf("vec%0d", v), vecs[v].sad, vecs[v].idx, vecs[v].dy, vecs[v].dx, 25);
        end

        // Gapped input, consumer stalled, next block's first line held on the bus throughout.
        model_reset();
        out_ready = 1'b0;
        for (int l = 0; l < 6; l++) push_line(rand_line(255), int'($urandom_range(0, 3)));
        x = rand_line(255);
        in_valid = 1'b1;
        diff_all = x;
        n = 0;
        cnt = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) cnt++;
            tick();
            n++;
        end
        check("stall latency", n, 25);
        check("stall in_ready in search", cnt, 0);
        model_best(s, i);
        check("stall sad", int'(best_sad), s);
        check("stall idx", int'(best_idx), i);
        hold_sad = best_sad;
        hold_idx = best_idx;
        hold_dy  = best_dy;
        hold_dx  = best_dx;
        cnt = 0;
        repeat (10) begin
            tick();
            if (best_sad != hold_sad || best_idx != hold_idx || best_dy != hold_dy ||
                best_dx != hold_dx || !out_valid || in_ready) cnt++;
        end
        check("stall hold", cnt, 0);
        out_ready = 1'b1;
        tick();
        check("stall handoff out_valid", int'(out_valid), 0);
        check("stall handoff in_ready", int'(in_ready), 1);
        model_reset();
        model_add(x);
        tick();
        in_valid = 1'b0;
        for (int l = 1; l < 6; l++) push_line(rand_line(255), int'($urandom_range(0, 2)));
        model_best(s, i);
        collect("stall next", s, i, i/5 - 2, i%5 - 2, 25);

        // Reset partway through accumulation: only the following block counts.
        for (int l = 0; l < 3; l++) push_line(rand_line(255), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst accum");
        model_reset();
        for (int l = 0; l < 6; l++) push_line(rand_line(255), int'($urandom_range(0, 1)));
        model_best(s, i);
        collect("rst accum next", s, i, i/5 - 2, i%5 - 2, 25);

        // Reset partway through the search: no result may appear afterwards.
        for (int l = 0; l < 6; l++) push_line(rand_line(255), 0);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst search");
        cnt = 0;
        repeat (40) begin
            tick();
            if (out_valid || !in_ready) cnt++;
        end
        check("rst search idle", cnt, 0);
        model_reset();
        for (int l = 0; l < 6; l++) push_line(rand_line(255), 0);
        model_best(s, i);
        collect("rst search next", s, i, i/5 - 2, i%5 - 2, 25);

        // Random blocks; small value ranges force frequent ties.
        for (int b = 0; b < 10; b++) begin
            case (b % 4)
                0: maxv = 0;
                1: maxv = 1;
                2: maxv = 3;
                default: maxv = 255;
            endcase
            model_reset();
            for (int l = 0; l < 6; l++) push_line(rand_line(maxv), int'($urandom_range(0, 3)));
            model_best(s, i);
            collect($sformatf("rand%0d", b), s, i, i/5 - 2, i%5 - 2, 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
